// File: rtl/fifo_sync_pkg.sv
`default_nettype none
// ============================================================================
// Module  : fifo_sync_pkg
// Purpose : Shared sizing and parameter-legality helpers for the synchronous
//           first-word-fall-through FIFO (fifo_sync_fwft) and its RAM.
// Revision: 1.0 - initial release
// ============================================================================
package fifo_sync_pkg;

    // Width of an occupancy counter that must represent 0..depth inclusive.
    function automatic int f_cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    // Width of a RAM address pointer; wraps naturally at depth-1 -> 0.
    function automatic int f_ptr_width(input int depth);
        return (depth < 2) ? 1 : $clog2(depth);
    endfunction

    // Depth must be a power of two within the supported range.
    function automatic logic f_depth_ok(input int depth);
        logic w_ok;
        w_ok = (depth >= 4) && (depth <= 65536) && ((depth & (depth - 1)) == 0);
        return w_ok;
    endfunction

    // Threshold offsets must lie strictly inside the FIFO capacity.
    function automatic logic f_offsets_ok(input int depth, input int aempty, input int afull);
        logic w_ok;
        w_ok = (aempty >= 0) && (afull >= 0) && (aempty < depth) && (afull < depth);
        return w_ok;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_sync_ram.sv
`default_nettype none
// ============================================================================
// Module  : fifo_sync_ram
// Purpose : Simple dual-port RAM, DSIZE x DEPTH, one write port and one read
//           port with a registered output. The read register only updates
//           when i_rd_en is high, so it holds its word while the consumer
//           stalls.
// Ports   : clk        - clock, rising edge
//           i_wr_en    - write strobe
//           i_wr_addr  - write address
//           i_wr_data  - write data
//           i_rd_en    - read enable (loads o_rd_data on the edge)
//           i_rd_addr  - read address
//           o_rd_data  - registered read data
// Revision: 1.0 - initial release
// ============================================================================
module fifo_sync_ram
    import fifo_sync_pkg::*;
#(
    parameter int DSIZE = 36,
    parameter int DEPTH = 512
) (
    input  logic                          clk,
    input  logic                          i_wr_en,
    input  logic [f_ptr_width(DEPTH)-1:0] i_wr_addr,
    input  logic [DSIZE-1:0]              i_wr_data,
    input  logic                          i_rd_en,
    input  logic [f_ptr_width(DEPTH)-1:0] i_rd_addr,
    output logic [DSIZE-1:0]              o_rd_data
);

    logic [DSIZE-1:0] r_mem [DEPTH];
    logic [DSIZE-1:0] r_rd_data;

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (i_rd_en) begin
            r_rd_data <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule
`default_nettype wire

// File: rtl/fifo_sync_fwft.sv
`default_nettype none
// ============================================================================
// Module  : fifo_sync_fwft
// Purpose : Single-clock first-word-fall-through FIFO with occupancy count,
//           almost-full / almost-empty thresholds and optional sticky error
//           flags. Storage is an inferred RAM plus a one-word output register;
//           the head word is presented on dout whenever empty is low.
// Macro   : FIFO_SYNC_ERR_EN - when defined, wr_err/rd_err latch overflow /
//           underflow events until err_clr or rst. When undefined both flags
//           are tied low and err_clr is ignored.
// Ports   : clock        - sole clock, rising edge
//           rst          - asynchronous active-high reset
//           din/wr_en    - write data / write request
//           rd_en        - pop the word currently on dout
//           dout         - head-of-FIFO data
//           full/empty   - capacity flags
//           almost_full  - count >= DEPTH-AFULL_OFFSET
//           almost_empty - count <= AEMPTY_OFFSET
//           count        - words held, including the word on dout
//           wr_err/rd_err- sticky overflow / underflow flags
//           err_clr      - synchronous clear of the sticky flags
// Revision: 1.0 - initial release
// ============================================================================
module fifo_sync_fwft
    import fifo_sync_pkg::*;
#(
    parameter int DSIZE         = 36,
    parameter int DEPTH         = 512,
    parameter int AEMPTY_OFFSET = 16,
    parameter int AFULL_OFFSET  = 16
) (
    input  logic                          clock,
    input  logic                          rst,
    input  logic [DSIZE-1:0]              din,
    input  logic                          wr_en,
    input  logic                          rd_en,
    output logic [DSIZE-1:0]              dout,
    output logic                          full,
    output logic                          empty,
    output logic                          almost_full,
    output logic                          almost_empty,
    output logic [f_cnt_width(DEPTH)-1:0] count,
    output logic                          wr_err,
    output logic                          rd_err,
    input  logic                          err_clr
);

    localparam int c_ptr_w = f_ptr_width(DEPTH);
    localparam int c_cnt_w = f_cnt_width(DEPTH);

    localparam logic [c_cnt_w-1:0] c_full_lvl   = c_cnt_w'(DEPTH);
    localparam logic [c_cnt_w-1:0] c_afull_lvl  = c_cnt_w'(DEPTH - AFULL_OFFSET);
    localparam logic [c_cnt_w-1:0] c_aempty_lvl = c_cnt_w'(AEMPTY_OFFSET);
    localparam logic [c_cnt_w-1:0] c_cnt_one    = c_cnt_w'(1);
    localparam logic [c_ptr_w-1:0] c_ptr_one    = c_ptr_w'(1);

    // ------------------------------------------------------------------
    // Elaboration-time parameter checks
    // ------------------------------------------------------------------
    if (!f_depth_ok(DEPTH)) begin : g_depth_chk
        $error("fifo_sync_fwft: DEPTH must be a power of two in 4..65536");
    end
    if (!f_offsets_ok(DEPTH, AEMPTY_OFFSET, AFULL_OFFSET)) begin : g_offset_chk
        $error("fifo_sync_fwft: AEMPTY_OFFSET and AFULL_OFFSET must be below DEPTH");
    end

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_cnt_w-1:0] r_ram_cnt;     // words in RAM not yet read out
    logic               r_rd_pend;     // RAM read register holds an unclaimed word
    logic               r_out_valid;   // output register holds the head word
    logic [DSIZE-1:0]   r_dout;
    logic [c_cnt_w-1:0] r_count;
    logic               r_full;
    logic               r_almost_full;
    logic               r_almost_empty;

    logic [DSIZE-1:0]   w_ram_rdata;
    logic               w_wr_acc;
    logic               w_pop;
    logic               w_out_load;
    logic               w_pend_free;
    logic               w_ram_rd;
    logic [c_cnt_w-1:0] w_count_nxt;
    logic [c_cnt_w-1:0] w_ram_cnt_nxt;

    // Accept decisions use only registered flags, so a write while full is
    // dropped even when a read is popping in the same cycle.
    assign w_wr_acc = wr_en && !r_full;
    assign w_pop    = rd_en && r_out_valid;

    // Two-stage prefetch: the RAM read register acts as a holding slot in
    // front of the output register. A new RAM read is issued whenever that
    // slot is empty or is being drained into the output register this edge,
    // which sustains one word per cycle under back-to-back reads.
    assign w_out_load  = r_rd_pend && (!r_out_valid || w_pop);
    assign w_pend_free = !r_rd_pend || w_out_load;
    assign w_ram_rd    = (r_ram_cnt != '0) && w_pend_free;

    always_comb begin
        w_count_nxt = r_count;
        case ({w_wr_acc, w_pop})
            2'b10:   w_count_nxt = r_count + c_cnt_one;
            2'b01:   w_count_nxt = r_count - c_cnt_one;
            default: w_count_nxt = r_count;
        endcase
    end

    always_comb begin
        w_ram_cnt_nxt = r_ram_cnt;
        case ({w_wr_acc, w_ram_rd})
            2'b10:   w_ram_cnt_nxt = r_ram_cnt + c_cnt_one;
            2'b01:   w_ram_cnt_nxt = r_ram_cnt - c_cnt_one;
            default: w_ram_cnt_nxt = r_ram_cnt;
        endcase
    end

    fifo_sync_ram #(
        .DSIZE (DSIZE),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk       (clock),
        .i_wr_en   (w_wr_acc),
        .i_wr_addr (r_wr_ptr),
        .i_wr_data (din),
        .i_rd_en   (w_ram_rd),
        .i_rd_addr (r_rd_ptr),
        .o_rd_data (w_ram_rdata)
    );

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
            r_ram_cnt      <= '0;
            r_rd_pend      <= 1'b0;
            r_out_valid    <= 1'b0;
            r_dout         <= '0;
            r_count        <= '0;
            r_full         <= 1'b0;
            r_almost_full  <= 1'b0;
            r_almost_empty <= 1'b1;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_one;
            end
            if (w_ram_rd) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_one;
            end
            if (w_out_load) begin
                r_dout <= w_ram_rdata;
            end
            r_ram_cnt      <= w_ram_cnt_nxt;
            r_rd_pend      <= w_ram_rd || (r_rd_pend && !w_out_load);
            r_out_valid    <= w_out_load || (r_out_valid && !w_pop);
            r_count        <= w_count_nxt;
            r_full         <= (w_count_nxt == c_full_lvl);
            r_almost_full  <= (w_count_nxt >= c_afull_lvl);
            r_almost_empty <= (w_count_nxt <= c_aempty_lvl);
        end
    end

    assign dout         = r_dout;
    assign full         = r_full;
    assign empty        = !r_out_valid;
    assign almost_full  = r_almost_full;
    assign almost_empty = r_almost_empty;
    assign count        = r_count;

    // ------------------------------------------------------------------
    // Sticky error flags
    // ------------------------------------------------------------------
`ifdef FIFO_SYNC_ERR_EN
    logic r_wr_err;
    logic r_rd_err;
    logic w_overflow;
    logic w_underflow;

    assign w_overflow  = wr_en && r_full;
    assign w_underflow = rd_en && !r_out_valid;

    // A new event wins over a simultaneous clear.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            r_wr_err <= 1'b0;
            r_rd_err <= 1'b0;
        end else begin
            if (w_overflow) begin
                r_wr_err <= 1'b1;
            end else if (err_clr) begin
                r_wr_err <= 1'b0;
            end
            if (w_underflow) begin
                r_rd_err <= 1'b1;
            end else if (err_clr) begin
                r_rd_err <= 1'b0;
            end
        end
    end

    assign wr_err = r_wr_err;
    assign rd_err = r_rd_err;
`else
    logic w_unused_err_clr;
    assign w_unused_err_clr = err_clr;
    assign wr_err = 1'b0;
    assign rd_err = 1'b0;
`endif

endmodule
`default_nettype wire
